// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts a one-cycle bubble when the decode instruction reads the
// destination of a load currently in EX. It also honours a memory hold
// that freezes the stage and a branch flush that squashes the slot, and
// counts the bubbles it inserts.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal flow; a load-use hazard may be detected
// BUBBLE | a load-use bubble was just written; EX holds no instruction
module id_ex_hazard_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ID_VALID,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic [4:0]       ID_RD,
  input  logic             ID_RS1_USED,
  input  logic             ID_RS2_USED,
  input  logic             ID_REGWRITE,
  input  logic             ID_MEMREAD,
  input  logic             HOLD,
  input  logic             FLUSH,
  output logic             EX_VALID,
  output logic [XLEN-1:0]  EX_PC,
  output logic [4:0]       EX_RS1,
  output logic [4:0]       EX_RS2,
  output logic [4:0]       EX_RD,
  output logic             EX_RS1_USED,
  output logic             EX_RS2_USED,
  output logic             EX_REGWRITE,
  output logic             EX_MEMREAD,
  output logic             STALL,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic rs1_hit;
  logic rs2_hit;
  logic lu;
  logic write_bubble;
  logic write_load;
  logic cnt_inc;

  // Load-use detection. The BUBBLE term is redundant with EX_VALID=0 in
  // that state, but makes it explicit that a stall never repeats.
  always_comb begin
    rs1_hit = ID_RS1_USED & (ID_RS1 == EX_RD);
    rs2_hit = ID_RS2_USED & (ID_RS2 == EX_RD);
    lu      = ID_VALID & EX_VALID & EX_MEMREAD & EX_REGWRITE &
              (EX_RD != 5'd0) & (rs1_hit | rs2_hit) & (state_q == ST_RUN);
  end

  assign STALL = lu & ~FLUSH & ~HOLD;

  // Next state and register-update selection; HOLD beats FLUSH beats LU.
  always_comb begin
    state_d      = state_q;
    write_bubble = 1'b0;
    write_load   = 1'b0;
    cnt_inc      = 1'b0;
    if (!HOLD) begin
      if (FLUSH) begin
        write_bubble = 1'b1;
        state_d      = ST_RUN;
      end else if (lu) begin
        write_bubble = 1'b1;
        cnt_inc      = 1'b1;
        state_d      = ST_BUBBLE;
      end else begin
        state_d = ST_RUN;
        if (ID_VALID) begin
          write_load = 1'b1;
        end else begin
          write_bubble = 1'b1;
        end
      end
    end
  end

  // Pipeline register, bubble counter and FSM state with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      EX_VALID    <= 1'b0;
      EX_PC       <= '0;
      EX_RS1      <= '0;
      EX_RS2      <= '0;
      EX_RD       <= '0;
      EX_RS1_USED <= 1'b0;
      EX_RS2_USED <= 1'b0;
      EX_REGWRITE <= 1'b0;
      EX_MEMREAD  <= 1'b0;
      STALL_CNT   <= '0;
    end else begin
      state_q <= state_d;
      if (write_bubble) begin
        EX_VALID    <= 1'b0;
        EX_PC       <= '0;
        EX_RS1      <= '0;
        EX_RS2      <= '0;
        EX_RD       <= '0;
        EX_RS1_USED <= 1'b0;
        EX_RS2_USED <= 1'b0;
        EX_REGWRITE <= 1'b0;
        EX_MEMREAD  <= 1'b0;
      end else if (write_load) begin
        EX_VALID    <= 1'b1;
        EX_PC       <= ID_PC;
        EX_RS1      <= ID_RS1;
        EX_RS2      <= ID_RS2;
        EX_RD       <= ID_RD;
        EX_RS1_USED <= ID_RS1_USED;
        EX_RS2_USED <= ID_RS2_USED;
        EX_REGWRITE <= ID_REGWRITE;
        EX_MEMREAD  <= ID_MEMREAD;
      end
      if (cnt_inc && (STALL_CNT != {CNT_W{1'b1}})) begin
        STALL_CNT <= STALL_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg. A small behavioural model
// pushes the expected EX/STALL_CNT contents into a queue as each cycle is
// driven; scenario tasks pop and compare after the clock edge.
module tb_id_ex_hazard_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int OW    = 1 + XLEN + 15 + 4 + CNT_W;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            u1;
    logic            u2;
    logic            rw;
    logic            mr;
  } instr_t;

  logic clk = 1'b0;
  logic rst, hold, flush;
  instr_t id_s;

  logic             ex_valid, ex_rs1_used, ex_rs2_used, ex_regwrite, ex_memread, stall;
  logic [XLEN-1:0]  ex_pc;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [CNT_W-1:0] stall_cnt;

  instr_t           m_ex;
  logic [CNT_W-1:0] m_cnt;
  logic [OW-1:0]    exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst),
    .ID_VALID(id_s.valid), .ID_PC(id_s.pc), .ID_RS1(id_s.rs1), .ID_RS2(id_s.rs2),
    .ID_RD(id_s.rd), .ID_RS1_USED(id_s.u1), .ID_RS2_USED(id_s.u2),
    .ID_REGWRITE(id_s.rw), .ID_MEMREAD(id_s.mr),
    .HOLD(hold), .FLUSH(flush),
    .EX_VALID(ex_valid), .EX_PC(ex_pc), .EX_RS1(ex_rs1), .EX_RS2(ex_rs2), .EX_RD(ex_rd),
    .EX_RS1_USED(ex_rs1_used), .EX_RS2_USED(ex_rs2_used),
    .EX_REGWRITE(ex_regwrite), .EX_MEMREAD(ex_memread),
    .STALL(stall), .STALL_CNT(stall_cnt)
  );

  function automatic logic [OW-1:0] obs();
    return {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_used, ex_rs2_used,
            ex_regwrite, ex_memread, stall_cnt};
  endfunction

  function automatic instr_t mk(logic [XLEN-1:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic u1, logic u2, logic rw, logic mr);
    instr_t t;
    t = '{valid: 1'b1, pc: pc, rs1: rs1, rs2: rs2, rd: rd, u1: u1, u2: u2, rw: rw, mr: mr};
    return t;
  endfunction

  // One clock: sample STALL, advance the model, push the expectation, clock.
  task automatic tick(output logic s_got, output logic s_exp);
    logic lu;
    #1;
    s_got = stall;
    lu = id_s.valid & m_ex.valid & m_ex.mr & m_ex.rw & (m_ex.rd != 5'd0) &
         ((id_s.u1 & (id_s.rs1 == m_ex.rd)) | (id_s.u2 & (id_s.rs2 == m_ex.rd)));
    s_exp = lu & ~flush & ~hold;
    if (rst) begin
      m_ex  = '0;
      m_cnt = '0;
    end else if (hold) begin
      m_ex = m_ex;
    end else if (flush) begin
      m_ex = '0;
    end else if (lu) begin
      m_ex = '0;
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else begin
      m_ex = id_s.valid ? id_s : '0;
    end
    exp_q.push_back({m_ex, m_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic sg, se;
    logic [OW-1:0] e;
    rst = 1'b1; hold = 1'b1; flush = 1'b1;
    id_s = mk(32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(sg, se);
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== '0) begin
      miscompares++;
      $display("FAIL reset_state got %h want 0", obs());
    end
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL reset_model got %h want %h", obs(), e);
    end
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    id_s = '0;
    for (int i = 0; i < 2; i++) begin
      tick(sg, se);
      e = exp_q.pop_front();
      vectors++;
      if (sg !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stall got %b want 0", sg);
      end
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL reset_idle got %h want %h", obs(), e);
      end
    end
  endtask

  task automatic test_pass_through();
    logic sg, se;
    logic [OW-1:0] e;
    for (int i = 0; i < 10; i++) begin
      id_s = mk($urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      id_s.valid = (i % 4 != 3);
      tick(sg, se);
      e = exp_q.pop_front();
      vectors++;
      if (sg !== se) begin
        miscompares++;
        $display("FAIL pass_stall[%0d] got %b want %b", i, sg, se);
      end
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL pass_ex[%0d] got %h want %h", i, obs(), e);
      end
    end
  endtask

  // Load x<rd> then a consumer; reports STALL and outputs for both cycles.
  task automatic test_load_use();
    logic sg, se;
    logic [OW-1:0] e;
    instr_t seq[3];
    logic   want_stall[3];
    seq[0] = mk(32'h200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    seq[1] = mk(32'h204, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    seq[2] = seq[1];
    want_stall = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      id_s = seq[i];
      tick(sg, se);
      e = exp_q.pop_front();
      vectors++;
      if (sg !== want_stall[i] || sg !== se) begin
        miscompares++;
        $display("FAIL lu_stall[%0d] got %b want %b", i, sg, want_stall[i]);
      end
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL lu_ex[%0d] got %h want %h", i, obs(), e);
      end
    end
    vectors++;
    if (stall_cnt !== 4'd1 || ex_pc !== 32'h204 || ex_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_result cnt %0d pc %h v %b want 1 204 1", stall_cnt, ex_pc, ex_valid);
    end
    // rs2 path
    seq[0] = mk(32'h300, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    seq[1] = mk(32'h304, 5'd1, 5'd9, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    seq[2] = seq[1];
    for (int i = 0; i < 3; i++) begin
      id_s = seq[i];
      tick(sg, se);
      e = exp_q.pop_front();
      vectors++;
      if (sg !== want_stall[i] || sg !== se) begin
        miscompares++;
        $display("FAIL lu2_stall[%0d] got %b want %b", i, sg, want_stall[i]);
      end
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL lu2_ex[%0d] got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_no_stall();
    logic sg, se;
    logic [OW-1:0] e;
    instr_t seq[6];
    seq[0] = mk(32'h400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    seq[1] = mk(32'h404, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    seq[2] = mk(32'h408, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    seq[3] = mk(32'h40c, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    seq[4] = mk(32'h410, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    seq[5] = mk(32'h414, 5'd24, 5'd9, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      id_s = seq[i];
      tick(sg, se);
      e = exp_q.pop_front();
      vectors++;
      if (sg !== 1'b0 || se !== 1'b0) begin
        miscompares++;
        $display("FAIL nostall[%0d] got %b want 0", i, sg);
      end
      vectors++;
      if (obs() !== e || ex_pc !== seq[i].pc) begin
        miscompares++;
        $display("FAIL nostall_ex[%0d] got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_flush();
    logic sg, se;
    logic [OW-1:0] e;
    logic [CNT_W-1:0] c0;
    id_s = mk(32'h500, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(sg, se);
    e = exp_q.pop_front();
    c0 = stall_cnt;
    id_s = mk(32'h504, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    tick(sg, se);
    e = exp_q.pop_front();
    flush = 1'b0;
    vectors++;
    if (sg !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stall got %b want 0", sg);
    end
    vectors++;
    if (obs() !== e || ex_valid !== 1'b0 || stall_cnt !== c0) begin
      miscompares++;
      $display("FAIL flush_ex got %h want %h", obs(), e);
    end
    tick(sg, se);
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e || ex_pc !== 32'h504) begin
      miscompares++;
      $display("FAIL flush_after got %h want %h", obs(), e);
    end
  endtask

  task automatic test_hold();
    logic sg, se;
    logic [OW-1:0] e, frozen;
    id_s = mk(32'h600, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(sg, se);
    e = exp_q.pop_front();
    frozen = obs();
    id_s = mk(32'h604, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(sg, se);
      e = exp_q.pop_front();
      vectors++;
      if (sg !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stall[%0d] got %b want 0", i, sg);
      end
      vectors++;
      if (obs() !== frozen || obs() !== e) begin
        miscompares++;
        $display("FAIL hold_frozen[%0d] got %h want %h", i, obs(), frozen);
      end
    end
    hold = 1'b0;
    tick(sg, se);
    e = exp_q.pop_front();
    vectors++;
    if (sg !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release_stall got %b want 1", sg);
    end
    vectors++;
    if (obs() !== e || ex_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release_ex got %h want %h", obs(), e);
    end
    tick(sg, se);
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e || ex_pc !== 32'h604) begin
      miscompares++;
      $display("FAIL hold_after got %h want %h", obs(), e);
    end
  endtask

  task automatic test_saturate();
    logic sg, se;
    logic [OW-1:0] e;
    for (int k = 0; k < (1 << CNT_W) + 1; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (j == 0) id_s = mk(32'h700 + k, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
        else        id_s = mk(32'h800 + k, 5'd3, 5'd12, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(sg, se);
        e = exp_q.pop_front();
        vectors++;
        if (sg !== se || obs() !== e) begin
          miscompares++;
          $display("FAIL sat[%0d.%0d] stall %b/%b ex %h want %h", k, j, sg, se, obs(), e);
        end
      end
    end
    vectors++;
    if (stall_cnt !== {CNT_W{1'b1}}) begin
      miscompares++;
      $display("FAIL sat_cnt got %0d want %0d", stall_cnt, (1 << CNT_W) - 1);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic sg, se;
    logic [OW-1:0] e;
    id_s = mk(32'h900, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(sg, se);
    e = exp_q.pop_front();
    id_s = mk(32'h904, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(sg, se);
    e = exp_q.pop_front();
    vectors++;
    if (sg !== 1'b1) begin
      miscompares++;
      $display("FAIL rms_stall got %b want 1", sg);
    end
    rst = 1'b1; hold = 1'b1; flush = 1'b1;
    tick(sg, se);
    e = exp_q.pop_front();
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    vectors++;
    if (obs() !== '0 || obs() !== e) begin
      miscompares++;
      $display("FAIL rms_zero got %h want 0", obs());
    end
    tick(sg, se);
    e = exp_q.pop_front();
    vectors++;
    if (sg !== 1'b0 || obs() !== e || ex_pc !== 32'h904) begin
      miscompares++;
      $display("FAIL rms_after stall %b ex %h want 0 %h", sg, obs(), e);
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; id_s = '0;
    m_ex = '0; m_cnt = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_stall();
    test_flush();
    test_hold();
    test_reset_mid_stall();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
